// File: rtl/mem_sync_if.sv
// mem_sync_if: write/read/clear bus of the synchronous-read dual-port memory.
interface mem_sync_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) ();
    logic                  clear_start;
    logic                  busy;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;

    modport master (
        output clear_start, write_en, write_addr, write_data, read_en, read_addr,
        input  busy, read_data, read_valid
    );
    modport slave (
        input  clear_start, write_en, write_addr, write_data, read_en, read_addr,
        output busy, read_data, read_valid
    );
endinterface

// File: rtl/mem_sync.sv
// mem_sync: simple dual-port memory with registered 1/2-cycle read, selectable
// read-during-write bypass and a clear sweep that runs after reset or on request.
module mem_sync #(
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    DEPTH        = 16,
    parameter int                    READ_LATENCY = 1,
    parameter int                    BYPASS       = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic      clk,
    input  logic      rst,
    mem_sync_if.slave bus_io
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] s1_data_q, rd_data_q, cap_d, out_data_d;
    logic                  s1_valid_q, rd_valid_q;
    logic                  wr_in_d, rd_in_d, wr_acc_d, rd_acc_d, out_valid_d, clr_last_d;

    assign wr_in_d     = {1'b0, bus_io.write_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign rd_in_d     = {1'b0, bus_io.read_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign wr_acc_d    = state_q == IDLE && bus_io.write_en && wr_in_d;
    assign rd_acc_d    = state_q == IDLE && bus_io.read_en;
    assign clr_last_d  = clr_addr_q == ADDR_WIDTH'(DEPTH - 1);
    // Out-of-range reads never see the array, so they cannot alias a real word.
    assign cap_d       = !rd_in_d ? CLEAR_VALUE :
                         (BYPASS != 0 && wr_acc_d && bus_io.write_addr == bus_io.read_addr) ?
                         bus_io.write_data : mem_q[bus_io.read_addr[IW-1:0]];
    assign out_valid_d = READ_LATENCY == 2 ? s1_valid_q : rd_acc_d;
    assign out_data_d  = READ_LATENCY == 2 ? s1_data_q : cap_d;

    always_ff @(posedge clk)
        if (state_q == CLEAR) mem_q[clr_addr_q[IW-1:0]] <= CLEAR_VALUE;
        else if (wr_acc_d) mem_q[bus_io.write_addr[IW-1:0]] <= bus_io.write_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_addr_q <= clr_addr_q + 1'b1;
            if (clr_last_d) state_q <= IDLE;
        end else if (bus_io.clear_start) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end

    // Pipeline keeps draining during a clear, so in-flight reads still complete.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc_d;
            if (rd_acc_d) s1_data_q <= cap_d;
            rd_valid_q <= out_valid_d;
            if (out_valid_d) rd_data_q <= out_data_d;
        end

    assign bus_io.busy       = state_q == CLEAR;
    assign bus_io.read_data  = rd_data_q;
    assign bus_io.read_valid = rd_valid_q;
endmodule
